syn_sram_acc_ctrl: RTL and testbench
====================================

SYN_SRAM_ACC_CTRL -- requirements
Module: syn_sram_acc_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk_ir; reset SHALL be rst_il, asynchronous, active-low.
REQ-002 Parameter P_FIFO_DEPTH, default 4: command FIFO depth, power of two, minimum 2.
REQ-003 clk_ir  in  1  system clock (50MHz cortex clock).
REQ-004 rst_il  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  command valid.
REQ-006 req_ready  out  1  command FIFO not full.
REQ-007 req_wr  in  1  1=write, 0=read.
REQ-008 req_addr  in  18  SRAM word address.
REQ-009 req_be  in  2  byte enables, active-high; [1]=upper byte, [0]=lower byte.
REQ-010 req_wdata  in  16  write data.
REQ-011 rsp_valid  out  1  one-cycle read-data strobe.
REQ-012 rsp_rdata  out  16  read data; disabled bytes are 0.
REQ-013 busy  out  1  FSM not IDLE or FIFO not empty.
REQ-014 SRAM_DO  out  16  write data; the pad drives it only while SRAM_WE_N=0.
REQ-015 SRAM_DI  in  16  pad read data.
REQ-016 SRAM_ADDR  out  18  SRAM address.
REQ-017 SRAM_LB_N  out  1  lower byte mask, active-low.
REQ-018 SRAM_UB_N  out  1  upper byte mask, active-low.
REQ-019 SRAM_CE_N  out  1  chip enable, active-low.
REQ-020 SRAM_OE_N  out  1  output enable, active-low.
REQ-021 SRAM_WE_N  out  1  write enable, active-low.

Function
REQ-022 A command SHALL be accepted on a clock edge where req_valid=1 and req_ready=1; {wr,addr,be,wdata} SHALL be pushed into the FIFO in order, and req_valid while full SHALL have no effect.
REQ-023 The FSM SHALL have states IDLE, RD_SETUP, RD_CAPT, WR_SETUP, WR_PULSE and WR_HOLD; all SRAM_* outputs SHALL be registered.
REQ-024 From IDLE, RD_CAPT or WR_HOLD with the FIFO non-empty, the FSM SHALL pop the head and go to RD_SETUP or WR_SETUP; with the FIFO empty it SHALL go to IDLE.
REQ-025 In RD_SETUP and RD_CAPT the outputs SHALL be: CE_N=0, OE_N=0, WE_N=1, ADDR=cmd addr, LB_N=~be[0], UB_N=~be[1].
REQ-026 SRAM_DI SHALL be captured at the end of RD_CAPT; rsp_valid SHALL pulse for exactly one cycle on the following cycle, 3 cycles after accept from IDLE with the FIFO empty.
REQ-027 Back-to-back reads SHALL sustain 1 read per 2 cycles.
REQ-028 A write SHALL take 3 cycles: WR_SETUP (CE_N=0, OE_N=1, WE_N=1, ADDR/DO/byte masks valid), then WR_PULSE (WE_N=0), then WR_HOLD (WE_N=1, ADDR/DO held).
REQ-029 OE_N SHALL be 1 in every write state, so read-to-write turnaround is provided by WR_SETUP.
REQ-030 A command with be=0 SHALL execute with both masks high; a read with be=0 SHALL still produce rsp_valid with rsp_rdata=0.
REQ-031 In IDLE all SRAM_* control outputs SHALL be 1; ADDR and DO SHALL hold their last values.
REQ-032 A push and a pop in the same cycle SHALL leave the FIFO level unchanged; the FIFO has no bypass, so an accept into an empty FIFO is popped on the next edge.

Reset
REQ-033 While rst_il=0: CE_N=OE_N=WE_N=LB_N=UB_N=1, ADDR=0, DO=0, rsp_valid=0, rsp_rdata=0, busy=0, FIFO flushed, FSM in IDLE; req_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-034 Reset asserted mid-access SHALL abort the access immediately: a write in WR_PULSE SHALL be truncated, and no rsp_valid SHALL be issued for an aborted read.

Structure
REQ-035 The FSM state enum and the SRAM widths (18-bit address, 16-bit data, 2-bit byte enable) SHALL be defined in syn_global_pkg.
REQ-036 The command FIFO SHALL be a sub-module, syn_sram_cmd_fifo (registered output, full/empty flags, level count).

Verification
REQ-037 Write 0x3_FFFF/0xA5C3 with be=11 -> WE_N low for exactly 1 cycle with ADDR=0x3FFFF and DO=0xA5C3 stable in SETUP, PULSE and HOLD.
REQ-038 Read 0x00010 while the model drives 0x1234 -> rsp_valid 3 cycles after accept with rsp_rdata=0x1234.
REQ-039 Reads with be=01, then be=10, then be=00 of 0xBEEF -> rsp_rdata 0x00EF, then 0xBE00, then 0x0000.
REQ-040 Push 6 commands with req_valid held high -> req_ready drops after 4 are buffered; all 6 complete in order.
REQ-041 Sequence read, write, read at the same address -> second read returns the written value, and OE_N and WE_N are never both 0.
REQ-042 Assert rst_il during WR_PULSE -> WE_N=1 and CE_N=1 immediately, no rsp_valid, busy=0, FIFO empty.

Source files
------------

// File: rtl/syn_global_pkg.sv
// Shared widths, FSM state encoding and command record for the async SRAM controller.
package syn_global_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SETUP = 3'd1,
    RD_CAPT  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Zero every byte lane whose enable is low.
  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] data,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int b = 0; b < BE_W; b++) begin
      res[b*8 +: 8] = be[b] ? data[b*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/syn_sram_acc_ctrl_if.sv
// Request/response handshake bundle between a client and the SRAM access controller.
interface syn_sram_acc_ctrl_if;
  import syn_global_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/syn_sram_cmd_fifo.sv
// Command FIFO: flop-array storage, head word read straight from the array, full/empty/level flags.
module syn_sram_cmd_fifo
  import syn_global_pkg::*;
#(
  parameter  int P_DEPTH = 4,
  localparam int PTR_W   = $clog2(P_DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk_ir,
  input  logic             rst_il,
  input  logic             push_i,
  input  cmd_t             push_data_i,
  input  logic             pop_i,
  output cmd_t             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] level_o
);

  cmd_t             mem_q [P_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(P_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so the pointers wrap without an explicit compare.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_ir) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/syn_sram_acc_ctrl.sv
// Asynchronous SRAM access controller: buffered commands, 2-cycle reads, 3-cycle writes,
// every SRAM pin driven from a flop.
module syn_sram_acc_ctrl
  import syn_global_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 4
) (
  input  logic                clk_ir,
  input  logic                rst_il,
  syn_sram_acc_ctrl_if.slave  bus,
  output logic                busy,
  output logic [DATA_W-1:0]   SRAM_DO,
  input  logic [DATA_W-1:0]   SRAM_DI,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic                SRAM_LB_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N
);

  localparam int CNT_W = $clog2(P_FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              lb_n_q, lb_n_d;
  logic              ub_n_q, ub_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              ready_en_q, ready_en_d;

  cmd_t              push_cmd;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_level;
  logic              pop;
  logic              launch;

  assign push_cmd      = '{wr: bus.req_wr, addr: bus.req_addr, be: bus.req_be, wdata: bus.req_wdata};
  // Held low through reset so nothing is accepted until the first clock after release.
  assign bus.req_ready = ready_en_q & ~fifo_full;
  assign ready_en_d    = 1'b1;

  syn_sram_cmd_fifo #(
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_ir      (clk_ir),
    .rst_il      (rst_il),
    .push_i      (bus.req_valid & bus.req_ready),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    lb_n_d      = lb_n_q;
    ub_n_d      = ub_n_q;
    addr_d      = addr_q;
    do_d        = do_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    launch      = 1'b0;

    case (state_q)
      RD_SETUP: state_d = RD_CAPT;
      RD_CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mask_bytes(SRAM_DI, {~ub_n_q, ~lb_n_q});
        launch      = 1'b1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        we_n_d  = 1'b0;
      end
      WR_PULSE: begin
        state_d = WR_HOLD;
        we_n_d  = 1'b1;
      end
      IDLE, WR_HOLD: launch = 1'b1;
      default:       launch = 1'b1;
    endcase

    // Outputs are set up here for the state being entered, so the pins line up with state_q.
    if (launch) begin
      if (!fifo_empty) begin
        pop    = 1'b1;
        ce_n_d = 1'b0;
        we_n_d = 1'b1;
        addr_d = head.addr;
        lb_n_d = ~head.be[0];
        ub_n_d = ~head.be[1];
        if (head.wr) begin
          state_d = WR_SETUP;
          oe_n_d  = 1'b1;
          do_d    = head.wdata;
        end else begin
          state_d = RD_SETUP;
          oe_n_d  = 1'b0;
        end
      end else begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q     <= IDLE;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      addr_q      <= '0;
      do_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      addr_q      <= addr_d;
      do_q        <= do_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign busy          = (state_q != IDLE) || (fifo_level != '0);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign SRAM_CE_N     = ce_n_q;
  assign SRAM_OE_N     = oe_n_q;
  assign SRAM_WE_N     = we_n_q;
  assign SRAM_LB_N     = lb_n_q;
  assign SRAM_UB_N     = ub_n_q;
  assign SRAM_ADDR     = addr_q;
  assign SRAM_DO       = do_q;

endmodule

// File: tb/tb_syn_sram_acc_ctrl.sv
// Scoreboard bench for syn_sram_acc_ctrl with a behavioural SRAM on the pins.
module tb_syn_sram_acc_ctrl;
  import syn_global_pkg::*;

  logic        clk_ir = 1'b0;
  logic        rst_il = 1'b1;
  logic        busy;
  logic [15:0] sram_do;
  logic [15:0] sram_di = 16'hDEAD;
  logic [17:0] sram_addr;
  logic        lb_n, ub_n, ce_n, oe_n, we_n;

  syn_sram_acc_ctrl_if bus();

  syn_sram_acc_ctrl #(.P_FIFO_DEPTH(4)) dut (
    .clk_ir    (clk_ir),
    .rst_il    (rst_il),
    .bus       (bus),
    .busy      (busy),
    .SRAM_DO   (sram_do),
    .SRAM_DI   (sram_di),
    .SRAM_ADDR (sram_addr),
    .SRAM_LB_N (lb_n),
    .SRAM_UB_N (ub_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n)
  );

  always #10 clk_ir = ~clk_ir;

  typedef struct {
    logic [15:0] data;
    int          acc;
    bit          chk_lat;
    bit          chk_gap;
  } rd_exp_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_exp_t;

  typedef struct packed {
    logic        ce, oe, we, lb, ub;
    logic [17:0] addr;
    logic [15:0] dout;
  } snap_t;

  rd_exp_t     sb_rd[$];
  wr_exp_t     sb_wr[$];
  logic [15:0] sram_mem [logic [17:0]];
  logic [15:0] exp_mem  [logic [17:0]];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  rsp_cnt = 0;
  int  last_rsp_cyc = 0;
  bit  prev_rsp = 0;
  bit  overlap_seen = 0;
  int  hist_n = 0;
  snap_t   h1, h2, cur;
  rd_exp_t mon_rd;
  wr_exp_t mon_wr;
  logic [15:0] mdl_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bmask(input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
  endfunction

  function automatic logic [15:0] exp_rd(input logic [17:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return 16'h0000;
  endfunction

  always @(posedge clk_ir) cyc++;

  // Pad model: write on the WE_N-low cycle, drive read data while CE_N/OE_N are low.
  always @(negedge clk_ir) begin
    if (rst_il && !ce_n && !we_n) begin
      mdl_word = sram_rd(sram_addr);
      if (!lb_n) mdl_word[7:0]  = sram_do[7:0];
      if (!ub_n) mdl_word[15:8] = sram_do[15:8];
      sram_mem[sram_addr] = mdl_word;
    end
    sram_di = (!ce_n && !oe_n) ? sram_rd(sram_addr) : 16'hDEAD;
    if (!oe_n && !we_n) overlap_seen = 1'b1;
  end

  // Read responses against the read scoreboard.
  always @(negedge clk_ir) begin
    if (rst_il && bus.rsp_valid) begin
      rsp_cnt++;
      chk("rsp_one_cycle", {31'b0, prev_rsp}, 32'd0);
      if (sb_rd.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_rd = sb_rd.pop_front();
        chk("rd_data", {16'b0, bus.rsp_rdata}, {16'b0, mon_rd.data});
        if (mon_rd.chk_lat) chk("rd_latency", cyc - mon_rd.acc, 32'd3);
        if (mon_rd.chk_gap) chk("rd_gap", cyc - last_rsp_cyc, 32'd2);
        $display("RD  rdata=0x%04h exp=0x%04h cycle=%0d", bus.rsp_rdata, mon_rd.data, cyc);
      end
      last_rsp_cyc = cyc;
    end
    prev_rsp = rst_il && bus.rsp_valid;
  end

  // Write cycles: checked at the HOLD cycle using the SETUP and PULSE snapshots.
  always @(negedge clk_ir) begin
    if (!rst_il) begin
      hist_n = 0;
    end else begin
      cur = '{ce_n, oe_n, we_n, lb_n, ub_n, sram_addr, sram_do};
      if (hist_n >= 2 && !h1.we) begin
        chk("wr_pulse_len", {31'b0, cur.we}, 32'd1);
        chk("wr_setup_ctl", {29'b0, h2.ce, h2.oe, h2.we}, 32'b011);
        chk("wr_hold_ctl", {30'b0, cur.ce, cur.oe}, 32'b01);
        chk("wr_stable", {31'b0, (h2.addr == h1.addr) && (cur.addr == h1.addr) &&
                                 (h2.dout == h1.dout) && (cur.dout == h1.dout) &&
                                 (h2.lb == h1.lb) && (h2.ub == h1.ub)}, 32'd1);
        if (sb_wr.size() == 0) begin
          chk("wr_unexpected", 32'd1, 32'd0);
        end else begin
          mon_wr = sb_wr.pop_front();
          chk("wr_addr", {14'b0, h1.addr}, {14'b0, mon_wr.addr});
          chk("wr_data", {16'b0, h1.dout}, {16'b0, mon_wr.data});
          chk("wr_mask", {30'b0, h1.ub, h1.lb}, {30'b0, ~mon_wr.be[1], ~mon_wr.be[0]});
          $display("WR  addr=0x%05h data=0x%04h be=%b cycle=%0d", h1.addr, h1.dout, mon_wr.be, cyc);
        end
      end
      h2 = h1;
      h1 = cur;
      if (hist_n < 2) hist_n++;
    end
  end

  task automatic issue(input bit wr, input logic [17:0] a, input logic [1:0] be,
                       input logic [15:0] wd, input bit lat = 0, input bit gap = 0);
    int          guard;
    logic [15:0] w;
    guard         = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk_ir);
      guard++;
    end
    if (guard >= 200) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else if (wr) begin
      sb_wr.push_back('{a, wd, be});
      w = exp_rd(a);
      if (be[0]) w[7:0]  = wd[7:0];
      if (be[1]) w[15:8] = wd[15:8];
      exp_mem[a] = w;
    end else begin
      sb_rd.push_back('{bmask(exp_rd(a), be), cyc + 1, lat, gap});
    end
    @(negedge clk_ir);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || sb_rd.size() != 0 || sb_wr.size() != 0) && guard < 500) begin
      @(negedge clk_ir);
      guard++;
    end
    if (guard >= 500) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk_ir);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_at_abort;
    int guard;
    bit          r_wr;
    logic [17:0] r_a;
    logic [1:0]  r_be;
    logic [15:0] r_d;

    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    sram_mem[18'h00010] = 16'h1234;  exp_mem[18'h00010] = 16'h1234;
    sram_mem[18'h00020] = 16'hBEEF;  exp_mem[18'h00020] = 16'hBEEF;
    sram_mem[18'h00200] = 16'h0F0F;  exp_mem[18'h00200] = 16'h0F0F;

    #1 rst_il = 1'b0;
    repeat (3) @(negedge clk_ir);
    chk("rst_ctl", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_addr", {14'b0, sram_addr}, 32'd0);
    chk("rst_do", {16'b0, sram_do}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'b0, bus.rsp_rdata}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    rst_il = 1'b1;
    @(negedge clk_ir);
    chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    // Single full-word write at the top address.
    issue(1'b1, 18'h3FFFF, 2'b11, 16'hA5C3);
    wait_idle();
    chk("pad_3ffff", {16'b0, sram_rd(18'h3FFFF)}, 32'h0000A5C3);

    // Isolated read: latency from accept.
    issue(1'b0, 18'h00010, 2'b11, 16'h0000, 1'b1);
    wait_idle();

    // Byte-lane reads issued back to back.
    issue(1'b0, 18'h00020, 2'b01, 16'h0000);
    issue(1'b0, 18'h00020, 2'b10, 16'h0000, 1'b0, 1'b1);
    issue(1'b0, 18'h00020, 2'b00, 16'h0000, 1'b0, 1'b1);
    wait_idle();

    // Six writes with valid held: FIFO fills, then everything drains in order.
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 18'h00100 + 18'(i), 2'b11, 16'h1000 + 16'(i * 16'h0111));
    end
    chk("ready_full_after_6", {31'b0, bus.req_ready}, 32'd0);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 18'h00100 + 18'(i), 2'b11, 16'h0000);
    end
    wait_idle();

    // Read, write, read at one address.
    issue(1'b0, 18'h00200, 2'b11, 16'h0000);
    issue(1'b1, 18'h00200, 2'b11, 16'h5A5A);
    issue(1'b0, 18'h00200, 2'b11, 16'h0000);
    wait_idle();

    // Random mix over a small address window.
    for (int i = 0; i < 24; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_a  = 18'h00400 + 18'($urandom_range(0, 7));
      r_be = 2'($urandom_range(0, 3));
      r_d  = 16'($urandom);
      issue(r_wr, r_a, r_be, r_d);
    end
    wait_idle();

    // Reset in the middle of a write pulse with a read queued behind it.
    issue(1'b1, 18'h00300, 2'b11, 16'hCAFE);
    issue(1'b0, 18'h00010, 2'b11, 16'h0000);
    guard = 0;
    while (we_n !== 1'b0 && guard < 20) begin
      @(negedge clk_ir);
      guard++;
    end
    chk("we_pulse_seen", {31'b0, we_n}, 32'd0);
    #2 rst_il = 1'b0;
    sb_rd.delete();
    sb_wr.delete();
    rsp_at_abort = rsp_cnt;
    #1;
    chk("abort_we_n", {31'b0, we_n}, 32'd1);
    chk("abort_ce_n", {31'b0, ce_n}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    repeat (3) @(negedge clk_ir);
    rst_il = 1'b1;
    repeat (12) @(negedge clk_ir);
    chk("no_rsp_after_abort", rsp_cnt - rsp_at_abort, 32'd0);
    chk("idle_after_abort", {31'b0, busy}, 32'd0);
    chk("ready_after_abort", {31'b0, bus.req_ready}, 32'd1);

    issue(1'b0, 18'h00010, 2'b11, 16'h0000, 1'b1);
    wait_idle();

    chk("sb_rd_drained", sb_rd.size(), 32'd0);
    chk("sb_wr_drained", sb_wr.size(), 32'd0);
    chk("oe_we_overlap", {31'b0, overlap_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
